// File: rtl/next_pc_unit.sv
// rtl/next_pc_unit.sv - next fetch PC selection with optional direct-mapped BTB (enable with `define BTB_EN)
module next_pc_unit #(
  parameter int BTB_ENTRIES = 16,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      PC,
  input  logic             stall,
  input  logic             ex_redirect,
  input  logic [31:0]      ex_redirect_pc,
  input  logic             ex_is_branch,
  input  logic [31:0]      ex_pc,
  input  logic             ex_taken,
  input  logic [31:0]      ex_target,
  output logic [31:0]      PC_Next,
  output logic             pred_taken,
  output logic [CNT_W-1:0] mispredict_cnt
);

  logic [31:0] pc_plus4;
  logic [31:0] pred_target;

  assign pc_plus4 = PC + 32'd4;

  always_ff @(posedge clk) begin
    if (!rst) begin
      mispredict_cnt <= '0;
    end else if (ex_redirect && (mispredict_cnt != {CNT_W{1'b1}})) begin
      mispredict_cnt <= mispredict_cnt + 1'b1;
    end
  end

`ifdef BTB_EN
  localparam int IDX   = $clog2(BTB_ENTRIES);
  localparam int TAG_W = 30 - IDX;

  logic [BTB_ENTRIES-1:0] btb_valid;
  logic [TAG_W-1:0]       btb_tag    [BTB_ENTRIES];
  logic [31:0]            btb_target [BTB_ENTRIES];
  logic [1:0]             btb_ctr    [BTB_ENTRIES];

  logic [IDX-1:0]   rd_idx;
  logic [IDX-1:0]   wr_idx;
  logic [TAG_W-1:0] rd_tag;
  logic [TAG_W-1:0] wr_tag;
  logic             rd_hit;
  logic             wr_hit;
  logic             unused_ex_pc_bits;

  assign rd_idx = PC[IDX+1:2];
  assign rd_tag = PC[31:IDX+2];
  assign wr_idx = ex_pc[IDX+1:2];
  assign wr_tag = ex_pc[31:IDX+2];
  assign unused_ex_pc_bits = ^ex_pc[1:0];

  // Lookups are forced to miss while reset is asserted, before valid bits clear.
  assign rd_hit      = rst && btb_valid[rd_idx] && (btb_tag[rd_idx] == rd_tag);
  assign wr_hit      = btb_valid[wr_idx] && (btb_tag[wr_idx] == wr_tag);
  assign pred_taken  = rd_hit && btb_ctr[rd_idx][1];
  assign pred_target = btb_target[rd_idx];

  always_ff @(posedge clk) begin
    if (!rst) begin
      btb_valid <= '0;
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        btb_ctr[i] <= 2'd0;
      end
    end else if (ex_is_branch) begin
      if (wr_hit) begin
        if (ex_taken && (btb_ctr[wr_idx] != 2'd3)) begin
          btb_ctr[wr_idx] <= btb_ctr[wr_idx] + 2'd1;
        end else if (!ex_taken && (btb_ctr[wr_idx] != 2'd0)) begin
          btb_ctr[wr_idx] <= btb_ctr[wr_idx] - 2'd1;
        end
      end else if (ex_taken) begin
        btb_valid[wr_idx] <= 1'b1;
        btb_ctr[wr_idx]   <= 2'd2;
      end
    end
  end

  // Tag rewrite on a hit is harmless (same value), so taken resolves always write both.
  always_ff @(posedge clk) begin
    if (rst && ex_is_branch && ex_taken) begin
      btb_tag[wr_idx]    <= wr_tag;
      btb_target[wr_idx] <= ex_target;
    end
  end
`else
  logic unused_btb_inputs;

  assign unused_btb_inputs = ^{ex_is_branch, ex_pc, ex_taken, ex_target};
  assign pred_taken        = 1'b0;
  assign pred_target       = pc_plus4;
`endif

  always_comb begin
    PC_Next = pc_plus4;
    if (ex_redirect) begin
      PC_Next = ex_redirect_pc;
    end else if (stall) begin
      PC_Next = PC;
    end else if (pred_taken) begin
      PC_Next = pred_target;
    end
  end

endmodule

// File: tb/tb_next_pc_unit.sv
// tb/tb_next_pc_unit.sv - self-checking bench for next_pc_unit against a behavioural model
module tb_next_pc_unit;
  localparam int NE    = 16;
  localparam int CNT_W = 4;
`ifdef BTB_EN
  localparam bit HAS_BTB = 1'b1;
`else
  localparam bit HAS_BTB = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic [31:0]      PC;
  logic             stall;
  logic             ex_redirect;
  logic [31:0]      ex_redirect_pc;
  logic             ex_is_branch;
  logic [31:0]      ex_pc;
  logic             ex_taken;
  logic [31:0]      ex_target;
  logic [31:0]      PC_Next;
  logic             pred_taken;
  logic [CNT_W-1:0] mispredict_cnt;

  int checks   = 0;
  int failures = 0;

  bit          m_valid [NE];
  logic [31:0] m_tag   [NE];
  logic [31:0] m_tgt   [NE];
  int          m_ctr   [NE];
  int          m_cnt;

  next_pc_unit #(.BTB_ENTRIES(NE), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .PC(PC), .stall(stall),
    .ex_redirect(ex_redirect), .ex_redirect_pc(ex_redirect_pc),
    .ex_is_branch(ex_is_branch), .ex_pc(ex_pc), .ex_taken(ex_taken), .ex_target(ex_target),
    .PC_Next(PC_Next), .pred_taken(pred_taken), .mispredict_cnt(mispredict_cnt)
  );

  always #5 clk = ~clk;

  function automatic int idx_of(input logic [31:0] a);
    return int'((a / 4) % NE);
  endfunction

  function automatic logic [31:0] tag_of(input logic [31:0] a);
    return a / (4 * NE);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input bit r, input logic [31:0] pc, input bit st,
                      input bit rd, input logic [31:0] rpc,
                      input bit b, input logic [31:0] bpc, input bit tk, input logic [31:0] tg,
                      input string tag,
                      output logic [31:0] o_pcn, output logic o_pt, output int o_cnt);
    logic [31:0] exp_pcn;
    bit          hit;
    bit          pt;
    int          i;
    @(negedge clk);
    rst = r; PC = pc; stall = st; ex_redirect = rd; ex_redirect_pc = rpc;
    ex_is_branch = b; ex_pc = bpc; ex_taken = tk; ex_target = tg;
    #1;
    i   = idx_of(pc);
    hit = HAS_BTB && r && m_valid[i] && (m_tag[i] == tag_of(pc));
    pt  = hit && (m_ctr[i] >= 2);
    if (rd)       exp_pcn = rpc;
    else if (st)  exp_pcn = pc;
    else if (pt)  exp_pcn = m_tgt[i];
    else          exp_pcn = pc + 32'd4;
    chk({tag, "_pc_next"}, PC_Next, exp_pcn);
    chk({tag, "_pred_taken"}, {31'd0, pred_taken}, {31'd0, pt});
    chk({tag, "_mispredict_cnt"}, {{(32-CNT_W){1'b0}}, mispredict_cnt}, m_cnt);
    o_pcn = PC_Next; o_pt = pred_taken; o_cnt = int'(mispredict_cnt);
    @(posedge clk);
    if (!r) begin
      for (int k = 0; k < NE; k++) begin
        m_valid[k] = 1'b0;
        m_ctr[k]   = 0;
      end
      m_cnt = 0;
    end else begin
      if (rd && m_cnt < (1 << CNT_W) - 1) m_cnt++;
      if (HAS_BTB && b) begin
        i = idx_of(bpc);
        if (m_valid[i] && m_tag[i] == tag_of(bpc)) begin
          m_ctr[i] = tk ? ((m_ctr[i] < 3) ? m_ctr[i] + 1 : 3) : ((m_ctr[i] > 0) ? m_ctr[i] - 1 : 0);
          if (tk) m_tgt[i] = tg;
        end else if (tk) begin
          m_valid[i] = 1'b1;
          m_tag[i]   = tag_of(bpc);
          m_tgt[i]   = tg;
          m_ctr[i]   = 2;
        end
      end
    end
  endtask

  initial begin
    logic [31:0] pcn;
    logic        pt;
    int          cnt;
    logic [31:0] rpc, bpc, tg, pc;
    m_cnt = 0;
    for (int k = 0; k < NE; k++) begin
      m_valid[k] = 1'b0; m_ctr[k] = 0; m_tag[k] = '0; m_tgt[k] = '0;
    end

    // Reset with a coincident branch update and redirect that must be dropped.
    step(0, 32'h100, 0, 1, 32'h80, 1, 32'h100, 1, 32'h300, "rst0", pcn, pt, cnt);
    step(0, 32'h100, 0, 0, 0, 1, 32'h100, 1, 32'h300, "rst1", pcn, pt, cnt);
    step(1, 32'h100, 0, 0, 0, 0, 0, 0, 0, "after_rst", pcn, pt, cnt);
    chk("reset_pc_next", pcn, 32'h104);
    chk("reset_pred", {31'd0, pt}, 32'd0);
    chk("reset_cnt", cnt, 0);

    step(1, 32'h40, 0, 0, 0, 1, 32'h100, 1, 32'h200, "train", pcn, pt, cnt);
    step(1, 32'h100, 0, 0, 0, 0, 0, 0, 0, "taken_hit", pcn, pt, cnt);
    chk("taken_hit_const", pcn, HAS_BTB ? 32'h200 : 32'h104);

    step(1, 32'h40, 0, 0, 0, 1, 32'h100, 0, 32'h0, "nt1", pcn, pt, cnt);
    step(1, 32'h40, 0, 0, 0, 1, 32'h100, 0, 32'h0, "nt2", pcn, pt, cnt);
    step(1, 32'h100, 0, 0, 0, 0, 0, 0, 0, "weak_hit", pcn, pt, cnt);
    chk("weak_hit_const", pcn, 32'h104);

    step(1, 32'h100, 1, 1, 32'h80, 0, 0, 0, 0, "redirect", pcn, pt, cnt);
    chk("redirect_const", pcn, 32'h80);
    step(1, 32'h100, 1, 0, 0, 0, 0, 0, 0, "post_redirect", pcn, pt, cnt);
    chk("redirect_cnt_const", cnt, 1);

    step(1, 32'h40, 0, 0, 0, 1, 32'h100, 1, 32'h200, "retrain1", pcn, pt, cnt);
    step(1, 32'h40, 1, 0, 0, 1, 32'h100, 1, 32'h200, "retrain2_stalled", pcn, pt, cnt);
    step(1, 32'h100 + 4 * NE, 0, 0, 0, 0, 0, 0, 0, "alias", pcn, pt, cnt);
    chk("alias_const", pcn, 32'h100 + 4 * NE + 4);

    // Same-cycle update at the looked-up index must not be visible yet.
    step(1, 32'h100, 0, 0, 0, 1, 32'h100, 0, 32'h0, "same_cycle", pcn, pt, cnt);
    chk("same_cycle_const", pcn, HAS_BTB ? 32'h200 : 32'h104);
    step(1, 32'h100, 0, 0, 0, 0, 0, 0, 0, "after_same_cycle", pcn, pt, cnt);

    step(1, 32'hFFFF_FFFC, 0, 0, 0, 0, 0, 0, 0, "wrap", pcn, pt, cnt);
    chk("wrap_const", pcn, 32'h0);
    step(1, 32'hFFFF_FFFC, 1, 0, 0, 0, 0, 0, 0, "wrap_stall", pcn, pt, cnt);
    chk("wrap_stall_const", pcn, 32'hFFFF_FFFC);

    for (int n = 0; n < 20; n++) begin
      step(1, 32'h200, 0, 1, 32'h400 + 32'(4 * n), 0, 0, 0, 0, "sat", pcn, pt, cnt);
    end
    step(1, 32'h200, 0, 0, 0, 0, 0, 0, 0, "sat_end", pcn, pt, cnt);
    chk("sat_const", cnt, (1 << CNT_W) - 1);

    step(0, 32'h100, 0, 0, 0, 0, 0, 0, 0, "rst_mid", pcn, pt, cnt);
    for (int n = 0; n < 400; n++) begin
      pc  = 32'h100 + 32'(4 * $urandom_range(0, 7)) + ($urandom_range(0, 1) ? 32'(4 * NE) : 32'h0);
      bpc = 32'h100 + 32'(4 * $urandom_range(0, 7)) + ($urandom_range(0, 1) ? 32'(4 * NE) : 32'h0);
      if ($urandom_range(0, 29) == 0) pc = 32'hFFFF_FFFC;
      rpc = $urandom & 32'hFFFF_FFFC;
      tg  = $urandom & 32'hFFFF_FFFC;
      step(($urandom_range(0, 39) != 0), pc, ($urandom_range(0, 4) == 0),
           ($urandom_range(0, 7) == 0), rpc, ($urandom_range(0, 1) == 1), bpc,
           ($urandom_range(0, 2) != 0), tg, "rnd", pcn, pt, cnt);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
